// File: rtl/dual_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dual_core_mem_arbiter
// Purpose  : Round-robin arbiter sharing one single-port data RAM between two
//            cores, with a one-cycle read response and per-core stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module dual_core_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [1:0]                          core_req_i,
    input  logic [1:0]                          core_we_i,
    input  logic [1:0][DATA_WIDTH/8-1:0]        core_be_i,
    input  logic [1:0][ADDR_WIDTH-1:0]          core_addr_i,
    input  logic [1:0][DATA_WIDTH-1:0]          core_wdata_i,
    output logic [1:0]                          core_gnt_o,
    output logic [1:0]                          core_rvalid_o,
    output logic [DATA_WIDTH-1:0]               core_rdata_o,
    output logic                                mem_req_o,
    output logic                                mem_we_o,
    output logic [DATA_WIDTH/8-1:0]             mem_be_o,
    output logic [ADDR_WIDTH-1:0]               mem_addr_o,
    output logic [DATA_WIDTH-1:0]               mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]               mem_rdata_i,
    output logic [1:0][CNT_WIDTH-1:0]           stall_cnt_o
);

    localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(3);
    localparam logic [CNT_WIDTH-1:0]  c_cnt_max    = '1;

    logic       r_prio;
    logic       r_resp_valid;
    logic       r_resp_id;
    logic [1:0] w_req;
    logic       w_any;
    logic       w_winner;

    // Requests are masked during reset so no grant or RAM strobe escapes.
    always_comb begin
        w_req    = rst_i ? 2'b00 : core_req_i;
        w_any    = |w_req;
        w_winner = (&w_req) ? r_prio : w_req[1];
    end

    always_comb begin
        core_gnt_o = 2'b00;
        if (w_any) begin
            core_gnt_o[w_winner] = 1'b1;
        end
        mem_req_o   = w_any;
        mem_we_o    = core_we_i[w_winner];
        mem_be_o    = core_be_i[w_winner];
        mem_addr_o  = core_addr_i[w_winner] & c_align_mask;
        mem_wdata_o = core_wdata_i[w_winner];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
        end else begin
            r_resp_valid <= w_any;
            if (w_any) begin
                r_prio    <= ~w_winner;
                r_resp_id <= w_winner;
            end
        end
    end

    // A response registered just before reset must not surface during it.
    always_comb begin
        core_rvalid_o = 2'b00;
        if (r_resp_valid && !rst_i) begin
            core_rvalid_o[r_resp_id] = 1'b1;
        end
        core_rdata_o = mem_rdata_i;
    end

    for (genvar n = 0; n < 2; n++) begin : g_stall
        logic [CNT_WIDTH-1:0] r_cnt;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_cnt <= '0;
            end else if (w_req[n] && !core_gnt_o[n] && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        assign stall_cnt_o[n] = rst_i ? '0 : r_cnt;
    end

endmodule
`default_nettype wire
